// File: rtl/hub75_bcm_scan_driver.sv
// HUB75 panel driver: shifts frame-buffer bitplanes per row and shows them with binary-coded modulation.
// Optional HUB75_DEADTIME_EN inserts DEADTIME blank cycles between LATCH and SHOW.
module hub75_bcm_scan_driver #(
    parameter int unsigned NUM_COLS    = 64,
    parameter int unsigned SCAN_RATE   = 32,
    parameter int unsigned COLOR_DEPTH = 3,
    parameter int unsigned NUM_CHAINS  = 1,
    parameter int unsigned BASE_CYCLES = 8,
    parameter int unsigned DEADTIME    = 4,
    localparam int unsigned ROW_W = (SCAN_RATE > 1) ? $clog2(SCAN_RATE) : 1,
    localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int unsigned RGB_W = NUM_CHAINS * 6,
    localparam int unsigned PIX_W = RGB_W * COLOR_DEPTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en,
    output logic [ROW_W-1:0] pix_row,
    output logic [COL_W-1:0] pix_col,
    input  logic [PIX_W-1:0] pix_data,
    output logic             frame_start,
    output logic             frame_done,
    output logic [ROW_W-1:0] hub75_addr,
    output logic [RGB_W-1:0] hub75_rgb,
    output logic             hub75_clk,
    output logic             hub75_latch,
    output logic             hub75_oe_n
);

    localparam int unsigned BIT_W     = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
    localparam int unsigned SHIFT_LEN = 2 * NUM_COLS + 2;
    localparam int unsigned SHOW_MAX  = BASE_CYCLES << (COLOR_DEPTH - 1);
    localparam int unsigned DEAD_LEN  = (DEADTIME > 0) ? DEADTIME : 1;
    localparam int unsigned CNT_MAX0  = (SHIFT_LEN > SHOW_MAX) ? SHIFT_LEN : SHOW_MAX;
    localparam int unsigned CNT_MAX   = (CNT_MAX0 > DEAD_LEN) ? CNT_MAX0 : DEAD_LEN;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DEAD,
        ST_SHOW
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [ROW_W-1:0] pix_row_q, pix_row_d;
    logic [COL_W-1:0] pix_col_q, pix_col_d;
    logic [ROW_W-1:0] addr_q, addr_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             clk_q, clk_d;
    logic             latch_q, latch_d;
    logic             oe_n_q, oe_n_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;

    logic [CNT_W-1:0] show_last;
    logic             pix_rd;
    logic             pix_cap;

    // Current bitplane bit of every chain/half/colour in the returned pixel word
    logic [COLOR_DEPTH-1:0] plane_bits [RGB_W];
    logic [RGB_W-1:0]       rgb_sel;

    for (genvar j = 0; j < RGB_W; j++) begin : g_sel
        assign plane_bits[j] = pix_data[j*COLOR_DEPTH +: COLOR_DEPTH];
        assign rgb_sel[j]    = plane_bits[j][bit_q];
    end

    assign show_last = (CNT_W'(BASE_CYCLES) << bit_q) - CNT_W'(1);

    // Scan sequencing and registered pin values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        bit_d        = bit_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    row_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                cnt_d = '0;
`ifdef HUB75_DEADTIME_EN
                state_d = ST_DEAD;
`else
                state_d = ST_SHOW;
`endif
            end
            ST_DEAD: begin
                if (cnt_q == CNT_W'(DEAD_LEN - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == show_last) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(COLOR_DEPTH - 1)) begin
                        bit_d = '0;
                        if (row_q == ROW_W'(SCAN_RATE - 1)) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                    if (en) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Even SHIFT cycles issue reads; odd ones see the returned word
        pix_rd  = (state_d == ST_SHIFT) && !cnt_d[0] && (cnt_d < CNT_W'(2 * NUM_COLS));
        pix_cap = (state_q == ST_SHIFT) && cnt_q[0] && (cnt_q < CNT_W'(2 * NUM_COLS));

        pix_col_d     = pix_rd ? COL_W'(cnt_d >> 1) : pix_col_q;
        pix_row_d     = pix_rd ? row_d : pix_row_q;
        rgb_d         = pix_cap ? rgb_sel : rgb_q;
        clk_d         = (state_d == ST_SHIFT) && cnt_d[0] && (cnt_d >= CNT_W'(3));
        latch_d       = (state_d == ST_LATCH);
        oe_n_d        = (state_d != ST_SHOW);
        addr_d        = ((state_d == ST_LATCH) && (bit_d == '0)) ? row_d : addr_q;
        frame_start_d = (state_d == ST_SHIFT) && (cnt_d == '0) && (row_d == '0) && (bit_d == '0);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            row_q         <= '0;
            bit_q         <= '0;
            pix_row_q     <= '0;
            pix_col_q     <= '0;
            addr_q        <= '0;
            rgb_q         <= '0;
            clk_q         <= 1'b0;
            latch_q       <= 1'b0;
            oe_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            bit_q         <= bit_d;
            pix_row_q     <= pix_row_d;
            pix_col_q     <= pix_col_d;
            addr_q        <= addr_d;
            rgb_q         <= rgb_d;
            clk_q         <= clk_d;
            latch_q       <= latch_d;
            oe_n_q        <= oe_n_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign pix_row     = pix_row_q;
    assign pix_col     = pix_col_q;
    assign hub75_addr  = addr_q;
    assign hub75_rgb   = rgb_q;
    assign hub75_clk   = clk_q;
    assign hub75_latch = latch_q;
    assign hub75_oe_n  = oe_n_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_scan_driver.sv
// Bench for hub75_bcm_scan_driver: per-cycle timeline model derived from frame/row/bitplane arithmetic.
module tb_hub75_bcm_scan_driver;

    localparam int NC   = 4;
    localparam int SR   = 2;
    localparam int CD   = 2;
    localparam int CH   = 1;
    localparam int BASE = 2;
    localparam int DT   = 4;
`ifdef HUB75_DEADTIME_EN
    localparam int D = DT;
`else
    localparam int D = 0;
`endif
    localparam int SHIFT_LEN = 2 * NC + 2;
    localparam int ROW_LEN   = CD * (SHIFT_LEN + 1 + D) + BASE * ((1 << CD) - 1);
    localparam int FRAME_LEN = SR * ROW_LEN;
    localparam int RGBW      = CH * 6;

    logic                 clk_in;
    logic                 rst_in;
    logic                 en;
    logic [0:0]           pix_row;
    logic [1:0]           pix_col;
    logic [RGBW*CD-1:0]   pix_data;
    logic                 frame_start;
    logic                 frame_done;
    logic [0:0]           hub75_addr;
    logic [RGBW-1:0]      hub75_rgb;
    logic                 hub75_clk;
    logic                 hub75_latch;
    logic                 hub75_oe_n;

    logic [RGBW*CD-1:0]   mem [SR][NC];
    int                   errors = 0;
    int                   checks = 0;
    int                   m_addr;

    hub75_bcm_scan_driver #(
        .NUM_COLS(NC), .SCAN_RATE(SR), .COLOR_DEPTH(CD),
        .NUM_CHAINS(CH), .BASE_CYCLES(BASE), .DEADTIME(DT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .en(en),
        .pix_row(pix_row), .pix_col(pix_col), .pix_data(pix_data),
        .frame_start(frame_start), .frame_done(frame_done),
        .hub75_addr(hub75_addr), .hub75_rgb(hub75_rgb), .hub75_clk(hub75_clk),
        .hub75_latch(hub75_latch), .hub75_oe_n(hub75_oe_n)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Frame buffer with one cycle of read latency
    always @(posedge clk_in) pix_data <= mem[pix_row][pix_col];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        for (int r = 0; r < SR; r++)
            for (int c = 0; c < NC; c++)
                mem[r][c] = (RGBW*CD)'($urandom);
    endtask

    function automatic int plane_len(input int b);
        return SHIFT_LEN + 1 + D + (BASE << b);
    endfunction

    function automatic logic [RGBW-1:0] exp_rgb(input int r, input int c, input int b);
        logic [RGBW*CD-1:0] w;
        logic [RGBW-1:0]    v;
        w = mem[r][c];
        for (int j = 0; j < RGBW; j++) v[j] = w[j*CD + b];
        return v;
    endfunction

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_oe_n"}, 32'(hub75_oe_n), 32'd1);
        chk({tag, "_latch"}, 32'(hub75_latch), 32'd0);
        chk({tag, "_clk"}, 32'(hub75_clk), 32'd0);
        chk({tag, "_rgb"}, 32'(hub75_rgb), 32'd0);
        chk({tag, "_addr"}, 32'(hub75_addr), 32'd0);
        chk({tag, "_fstart"}, 32'(frame_start), 32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
    endtask

    // Timeline starts (t=0) at the first SHIFT cycle of a fresh frame; called at a negedge
    task automatic run_model(input int ncyc, input int act_at, input int act_kind);
        int  r, b, p, u;
        bit  e_clk;
        for (int t = 0; t < ncyc; t++) begin
            u = t % FRAME_LEN;
            r = u / ROW_LEN;
            u = u % ROW_LEN;
            b = 0;
            while (b < CD - 1 && u >= plane_len(b)) begin
                u -= plane_len(b);
                b++;
            end
            p = u;
            if (p == SHIFT_LEN && b == 0) m_addr = r;
            e_clk = (p < SHIFT_LEN) && (p >= 3) && (p % 2 == 1);
            chk($sformatf("oe_n@%0d", t), 32'(hub75_oe_n), (p > SHIFT_LEN + D) ? 32'd0 : 32'd1);
            chk($sformatf("latch@%0d", t), 32'(hub75_latch), 32'(p == SHIFT_LEN));
            chk($sformatf("clk@%0d", t), 32'(hub75_clk), 32'(e_clk));
            chk($sformatf("addr@%0d", t), 32'(hub75_addr), 32'(m_addr));
            chk($sformatf("fstart@%0d", t), 32'(frame_start), 32'(t % FRAME_LEN == 0));
            chk($sformatf("fdone@%0d", t), 32'(frame_done),
                32'((t >= FRAME_LEN) && (t % FRAME_LEN == 0)));
            if (e_clk)
                chk($sformatf("rgb@%0d_r%0d_b%0d", t, r, b), 32'(hub75_rgb),
                    32'(exp_rgb(r, (p - 3) / 2, b)));
            if (t == act_at) begin
                if (act_kind == 1) en = 1'b0;
                else rst_in = 1'b0;
            end
            @(negedge clk_in);
            if (t == act_at && act_kind == 2) break;
        end
    endtask

    initial begin
        int drop_at;
        int rst_at;

        fill_mem();
        en     = 1'b1;
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk_reset_pins("por");

        // Release reset: IDLE cycle already elapsed, next cycle starts row 0 bit 0
        rst_in = 1'b1;
        @(negedge clk_in);
        m_addr  = 0;
        drop_at = FRAME_LEN + ROW_LEN + int'($urandom_range(0, SHIFT_LEN - 1));
        run_model(FRAME_LEN + ROW_LEN + plane_len(0), drop_at, 1);

        // After en drop the bitplane finished; driver must sit blank with no frame_done
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("idle_oe_n%0d", i), 32'(hub75_oe_n), 32'd1);
            chk($sformatf("idle_fdone%0d", i), 32'(frame_done), 32'd0);
            chk($sformatf("idle_fstart%0d", i), 32'(frame_start), 32'd0);
            chk($sformatf("idle_latch%0d", i), 32'(hub75_latch), 32'd0);
            chk($sformatf("idle_clk%0d", i), 32'(hub75_clk), 32'd0);
            chk($sformatf("idle_addr%0d", i), 32'(hub75_addr), 32'(m_addr));
            @(negedge clk_in);
        end

        // Restart is a fresh frame; then reset during a SHOW of row 0 bit 1
        fill_mem();
        en = 1'b1;
        @(negedge clk_in);
        rst_at = ROW_LEN - 1 - int'($urandom_range(0, (BASE << (CD - 1)) - 1));
        run_model(ROW_LEN, rst_at, 2);
        chk_reset_pins("rst_show");
        @(negedge clk_in);
        chk_reset_pins("rst_hold");

        fill_mem();
        rst_in = 1'b1;
        @(negedge clk_in);
        m_addr = 0;
        run_model(2 * FRAME_LEN + 1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
